imem_loader: RTL

- Byte-stream program loader; the writer side of the instruction-memory load port (address / instruction_input / writememclk).
- Receives a framed byte stream: 16-bit word count, big-endian 32-bit instruction words, 1-byte XOR checksum.
- Writes one word per memory location, starting at BASE_ADDR.
- Holds the CPU (cpu_hold) until a load completes with a good checksum.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses [len16][BE words...][xor8], writes each word
// to instruction memory through a setup/strobe pair and releases the CPU on success.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       instruction_input,
    output logic              writememclk,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA    = 4'd3,
        S_WSETUP  = 4'd4,
        S_WSTROBE = 4'd5,
        S_CSUM    = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    localparam logic [16:0]       LEN_LIMIT = 17'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    // Handshake: a byte moves on a posedge where byte_valid && byte_ready; the
    // source holds byte_data stable until that edge.

    state_t              state, state_n;
    logic [15:0]         len, len_n;
    logic [15:0]         word_cnt, word_cnt_n;
    logic [1:0]          byte_idx, byte_idx_n;
    logic [23:0]         shreg, shreg_n;
    logic [7:0]          csum, csum_n;
    logic [ADDR_W-1:0]   address_n;
    logic [31:0]         instr_n;
    logic                byte_ready_n;
    logic                writememclk_n;
    logic                cpu_hold_n;
    logic                done_n;
    logic                error_n;
    logic                take;
    logic [15:0]         full_len;
    logic [15:0]         cnt_inc;

    assign take      = byte_valid && byte_ready;
    assign full_len  = {len[15:8], byte_data};
    assign cnt_inc   = word_cnt + 16'd1;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            len               <= '0;
            word_cnt          <= '0;
            byte_idx          <= '0;
            shreg             <= '0;
            csum              <= '0;
            address           <= BASE;
            instruction_input <= '0;
            byte_ready        <= 1'b0;
            writememclk       <= 1'b0;
            cpu_hold          <= 1'b1;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            state             <= state_n;
            len               <= len_n;
            word_cnt          <= word_cnt_n;
            byte_idx          <= byte_idx_n;
            shreg             <= shreg_n;
            csum              <= csum_n;
            address           <= address_n;
            instruction_input <= instr_n;
            byte_ready        <= byte_ready_n;
            writememclk       <= writememclk_n;
            cpu_hold          <= cpu_hold_n;
            done              <= done_n;
            error             <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        len_n      = len;
        word_cnt_n = word_cnt;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        csum_n     = csum;
        address_n  = address;
        instr_n    = instruction_input;

        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n    = S_LEN_HI;
                    csum_n     = '0;
                    word_cnt_n = '0;
                    byte_idx_n = '0;
                    address_n  = BASE;
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_n[15:8] = byte_data;
                    csum_n      = csum ^ byte_data;
                    state_n     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_n[7:0] = byte_data;
                    csum_n     = csum ^ byte_data;
                    // Rejecting oversize lengths here is what keeps address below DEPTH.
                    if ({1'b0, full_len} > LEN_LIMIT) begin
                        state_n = S_ERR;
                    end else if (full_len == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    csum_n = csum ^ byte_data;
                    if (byte_idx == 2'd3) begin
                        instr_n    = {shreg, byte_data};
                        byte_idx_n = '0;
                        state_n    = S_WSETUP;
                    end else begin
                        shreg_n    = {shreg[15:0], byte_data};
                        byte_idx_n = byte_idx + 2'd1;
                    end
                end
            end
            S_WSETUP: begin
                state_n = S_WSTROBE;
            end
            S_WSTROBE: begin
                word_cnt_n = cnt_inc;
                if (cnt_inc == len) begin
                    state_n = S_CSUM;
                end else begin
                    state_n   = S_DATA;
                    address_n = address + ADDR_W'(1);
                end
            end
            S_CSUM: begin
                if (take) begin
                    state_n = (byte_data == csum) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Status outputs are a pure function of the next state, registered.
        byte_ready_n  = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                        (state_n == S_DATA)   || (state_n == S_CSUM);
        writememclk_n = (state_n == S_WSTROBE);
        cpu_hold_n    = (state_n != S_DONE);
        done_n        = (state_n == S_DONE);
        error_n       = (state_n == S_ERR);
    end

endmodule
